// File: rtl/sw_pkt_rr_arbiter_pkg.sv
// Shared types and helpers for the packet round-robin arbiter slice.
package sw_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2
  } arb_state_e;

  localparam int LEN_LSB_DEF = 0;
  localparam int LEN_W_DEF   = 4;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sw_pkt_rr_arbiter_if.sv
// Registered downstream word stream with valid/ready handshake and packet delimiters.
interface sw_pkt_rr_arbiter_if #(
  parameter int W_WIDTH = 8
);
  logic [W_WIDTH-1:0] out_data;
  logic               out_valid;
  logic               out_sop;
  logic               out_eop;
  logic               out_ready;

  modport master (output out_data, out_valid, out_sop, out_eop, input out_ready);
  modport slave  (input out_data, out_valid, out_sop, out_eop, output out_ready);
endinterface

// File: rtl/sw_pkt_rr_arbiter_rr_prio_select.sv
// Rotating-priority find-first: first set request at or above ptr_i, wrapping modulo N.
module rr_prio_select
  import sw_arb_pkg::*;
#(
  parameter int N     = 5,
  parameter int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  localparam logic [IDX_W:0] N_L = (IDX_W+1)'(N);

  logic [IDX_W:0] cand;

  // Walk from the farthest candidate back to ptr_i so the nearest hit wins.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_i} + (IDX_W+1)'(k);
      if (cand >= N_L) cand = cand - N_L;
      if (req_i[cand[IDX_W-1:0]]) begin
        idx_o = cand[IDX_W-1:0];
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sw_pkt_rr_arbiter.sv
// Packet-level round-robin arbiter: one FIFO owns the output for a whole
// length-prefixed packet; a FIFO that stays empty mid-packet is aborted.
module sw_pkt_rr_arbiter
  import sw_arb_pkg::*;
#(
  parameter  int NUM_SW_INST   = 5,
  parameter  int W_WIDTH       = 8,
  parameter  int LEN_LSB       = LEN_LSB_DEF,
  parameter  int LEN_W         = LEN_W_DEF,
  parameter  int STALL_TIMEOUT = 16,
  localparam int IDX_W         = idx_w(NUM_SW_INST)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_SW_INST-1:0]         empty,
  input  logic [NUM_SW_INST*W_WIDTH-1:0] rd_data,
  output logic [NUM_SW_INST-1:0]         rd_en,
  sw_pkt_rr_arbiter_if.master            out_if,
  output logic [IDX_W-1:0]               grant_idx,
  output logic                           grant_vld,
  output logic                           abort_pulse
);

  localparam int              CNT_W     = $clog2(STALL_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] STALL_LST = CNT_W'(STALL_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_SW_INST - 1);

  logic [W_WIDTH-1:0] words [NUM_SW_INST];

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   grant_q, rr_ptr_q, ptr_after, sel_idx;
  logic               grant_vld_q, sel_any;
  logic [LEN_W-1:0]   words_left_q, hdr_len;
  logic [CNT_W-1:0]   stall_cnt_q;
  logic [W_WIDTH-1:0] out_data_q, head_word;
  logic               out_valid_q, out_sop_q, out_eop_q, abort_q;
  logic               busy, head_empty, can_load, pop, last_word, stall_hit;

  for (genvar i = 0; i < NUM_SW_INST; i++) begin : g_unpack
    assign words[i] = rd_data[i*W_WIDTH +: W_WIDTH];
  end

  rr_prio_select #(.N(NUM_SW_INST), .IDX_W(IDX_W)) u_sel (
    .req_i (~empty),
    .ptr_i (rr_ptr_q),
    .idx_o (sel_idx),
    .any_o (sel_any)
  );

  always_comb begin
    head_word  = words[grant_q];
    head_empty = empty[grant_q];
    hdr_len    = head_word[LEN_LSB +: LEN_W];
    busy       = (state_q != ST_IDLE);
    can_load   = !out_valid_q || out_if.out_ready;
    pop        = busy && !head_empty && can_load;
    last_word  = (state_q == ST_HEADER) ? (hdr_len == '0) : (words_left_q == LEN_W'(1));
    // Backpressured cycles neither count toward nor clear the stall timer.
    stall_hit  = busy && head_empty && can_load && (stall_cnt_q == STALL_LST);
    ptr_after  = (grant_q == IDX_LAST) ? '0 : grant_q + IDX_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (sel_any) state_d = ST_HEADER;
      ST_HEADER:  if (pop) state_d = last_word ? ST_IDLE : ST_PAYLOAD;
                  else if (stall_hit) state_d = ST_IDLE;
      ST_PAYLOAD: if ((pop && last_word) || stall_hit) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_en = '0;
    if (pop) rd_en[grant_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q      <= '0;
      grant_vld_q  <= 1'b0;
      rr_ptr_q     <= '0;
      words_left_q <= '0;
      stall_cnt_q  <= '0;
      abort_q      <= 1'b0;
    end else begin
      abort_q <= stall_hit;
      if (state_q == ST_IDLE) begin
        stall_cnt_q <= '0;
        if (sel_any) begin
          grant_q     <= sel_idx;
          grant_vld_q <= 1'b1;
        end
      end else if (pop) begin
        stall_cnt_q  <= '0;
        words_left_q <= (state_q == ST_HEADER) ? hdr_len : words_left_q - LEN_W'(1);
        if (last_word) begin
          grant_vld_q <= 1'b0;
          rr_ptr_q    <= ptr_after;
        end
      end else if (stall_hit) begin
        stall_cnt_q <= '0;
        grant_vld_q <= 1'b0;
        rr_ptr_q    <= ptr_after;
      end else if (head_empty && can_load) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  // Output stage: reload on pop, otherwise drain when the consumer takes the word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
    end else if (pop) begin
      out_data_q  <= head_word;
      out_valid_q <= 1'b1;
      out_sop_q   <= (state_q == ST_HEADER);
      out_eop_q   <= last_word;
    end else if (out_if.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_if.out_data  = out_data_q;
  assign out_if.out_valid = out_valid_q;
  assign out_if.out_sop   = out_sop_q;
  assign out_if.out_eop   = out_eop_q;
  assign grant_idx        = grant_q;
  assign grant_vld        = grant_vld_q;
  assign abort_pulse      = abort_q;

endmodule

// File: tb/tb_sw_pkt_rr_arbiter.sv
// Bench for sw_pkt_rr_arbiter: queue-backed FIFOs, packet-order reference model, directed and random runs.
module tb_sw_pkt_rr_arbiter;

  typedef struct packed {
    logic [7:0] d;
    logic       sop;
    logic       eop;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  empty;
  logic [39:0] rd_data;
  logic [4:0]  rd_en;
  logic [2:0]  grant_idx;
  logic        grant_vld, abort_pulse;

  sw_pkt_rr_arbiter_if #(.W_WIDTH(8)) oif ();

  sw_pkt_rr_arbiter #(
    .NUM_SW_INST(5), .W_WIDTH(8), .LEN_LSB(0), .LEN_W(4), .STALL_TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .empty(empty), .rd_data(rd_data), .rd_en(rd_en),
    .out_if(oif), .grant_idx(grant_idx), .grant_vld(grant_vld), .abort_pulse(abort_pulse)
  );

  always #5 clk = ~clk;

  logic [7:0] fq [5][$];
  ent_t       exp_q [$];
  int         gseq [$];
  int         total = 0, bad = 0, n_abort = 0, rdy_mode = 0, pat_i = 0;
  logic [3:0] pat = 4'b1001;
  bit         chk_en = 0, prev_stall = 0, prev_gv = 0;
  ent_t       prev_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic void refresh();
    for (int i = 0; i < 5; i++) begin
      empty[i] = (fq[i].size() == 0);
      rd_data[i*8 +: 8] = empty[i] ? 8'h00 : fq[i][0];
    end
  endfunction

  // Header carries len in [3:0]; only nw of the len payload words are supplied.
  task automatic push_pkt(input int f, input int len, input int nw);
    fq[f].push_back({4'($urandom_range(0, 15)), 4'(len)});
    for (int k = 0; k < nw; k++) fq[f].push_back(8'($urandom));
    refresh();
  endtask

  // Reference: serve whole packets, nearest non-empty FIFO from the pointer,
  // pointer moves past whichever FIFO was served (complete or truncated).
  task automatic build_exp(input int start);
    logic [7:0] mq [5][$];
    int p, sel, len;
    bit found;
    logic [7:0] h;
    for (int i = 0; i < 5; i++) mq[i] = fq[i];
    exp_q.delete();
    p = start;
    while (1) begin
      found = 0; sel = 0;
      for (int k = 0; k < 5; k++)
        if (!found && mq[(p + k) % 5].size() != 0) begin found = 1; sel = (p + k) % 5; end
      if (!found) break;
      h = mq[sel].pop_front();
      len = int'(h[3:0]);
      exp_q.push_back(ent_t'({h, 1'b1, len == 0}));
      for (int n = 1; n <= len && mq[sel].size() != 0; n++)
        exp_q.push_back(ent_t'({mq[sel].pop_front(), 1'b0, n == len}));
      p = (sel + 1) % 5;
    end
  endtask

  task automatic mon();
    ent_t e;
    if (rst_n && chk_en) begin
      chk("rden_on_empty", 32'(rd_en & empty), 32'd0);
      if (prev_stall) begin
        chk("hold_valid", 32'(oif.out_valid), 32'd1);
        chk("hold_word", 32'({oif.out_data, oif.out_sop, oif.out_eop}), 32'(prev_e));
      end
      if (oif.out_valid && oif.out_ready) begin
        chk("word_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("word", 32'({oif.out_data, oif.out_sop, oif.out_eop}), 32'(e));
        end
      end
      prev_stall = oif.out_valid && !oif.out_ready;
      prev_e = ent_t'({oif.out_data, oif.out_sop, oif.out_eop});
      if (abort_pulse) n_abort++;
      if (grant_vld && !prev_gv) gseq.push_back(int'(grant_idx));
    end else prev_stall = 0;
    prev_gv = grant_vld;
  endtask

  task automatic tick();
    logic [4:0] r;
    @(posedge clk);
    r = rd_en;
    #1;
    for (int i = 0; i < 5; i++) if (r[i] && fq[i].size() != 0) void'(fq[i].pop_front());
    refresh();
    case (rdy_mode)
      1:       oif.out_ready = 1'($urandom_range(0, 1));
      2:       begin oif.out_ready = pat[pat_i]; pat_i = (pat_i + 1) % 4; end
      default: oif.out_ready = 1'b1;
    endcase
    @(negedge clk);
    mon();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; chk_en = 0;
    for (int i = 0; i < 5; i++) fq[i].delete();
    exp_q.delete(); gseq.delete();
    n_abort = 0; prev_stall = 0; prev_gv = 0;
    refresh();
    tick(); tick();
    rst_n = 1'b1; chk_en = 1;
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < 5; i++) if (fq[i].size() != 0) return 0;
    return 1;
  endfunction

  task automatic drain(input int max);
    int n = 0;
    while (!(exp_q.size() == 0 && !oif.out_valid && !grant_vld && all_empty()) && n < max) begin
      tick(); n++;
    end
    chk("drain_done", 32'(n < max), 32'd1);
  endtask

  initial begin
    rst_n = 1'b1; oif.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) fq[i].delete();
    refresh();
    #2 rst_n = 1'b0;
    tick(); tick();
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_valid", 32'(oif.out_valid), 32'd0);
    chk("rst_sop", 32'(oif.out_sop), 32'd0);
    chk("rst_eop", 32'(oif.out_eop), 32'd0);
    chk("rst_data", 32'(oif.out_data), 32'd0);
    chk("rst_gidx", 32'(grant_idx), 32'd0);
    chk("rst_gvld", 32'(grant_vld), 32'd0);
    chk("rst_abort", 32'(abort_pulse), 32'd0);
    rst_n = 1'b1; chk_en = 1;

    // Single packet from FIFO2, len 3
    push_pkt(2, 3, 3);
    build_exp(0);
    tick();
    chk("sp_gvld", 32'(grant_vld), 32'd1);
    chk("sp_gidx", 32'(grant_idx), 32'd2);
    chk("sp_rden1", 32'(rd_en), 32'h04);
    chk("sp_nolat", 32'(oif.out_valid), 32'd0);
    tick();
    chk("sp_rden2", 32'(rd_en), 32'h04);
    chk("sp_sop", 32'({oif.out_valid, oif.out_sop}), 32'd3);
    tick(); chk("sp_rden3", 32'(rd_en), 32'h04);
    tick(); chk("sp_rden4", 32'(rd_en), 32'h04);
    tick();
    chk("sp_rden5", 32'(rd_en), 32'd0);
    chk("sp_eop", 32'({oif.out_valid, oif.out_eop}), 32'd3);
    chk("sp_gvld_off", 32'(grant_vld), 32'd0);
    push_pkt(0, 1, 1);
    push_pkt(4, 1, 1);
    build_exp(3);
    tick();
    chk("sp_next_after_ptr3", 32'(grant_idx), 32'd4);
    drain(100);

    // Fairness: two len-1 packets in every FIFO
    do_reset();
    for (int r = 0; r < 2; r++) for (int f = 0; f < 5; f++) push_pkt(f, 1, 1);
    build_exp(0);
    drain(200);
    chk("fair_count", 32'(gseq.size()), 32'd10);
    for (int k = 0; k < gseq.size() && k < 10; k++) chk("fair_order", 32'(gseq[k]), 32'(k % 5));

    // Backpressure with ready 1,0,0,1
    do_reset();
    rdy_mode = 2; pat_i = 0;
    push_pkt(3, 4, 4);
    build_exp(0);
    drain(200);
    chk("bp_no_abort", 32'(n_abort), 32'd0);
    rdy_mode = 0;

    // Stall timeout on FIFO1 after 2 of 5 payload words
    do_reset();
    push_pkt(1, 5, 2);
    push_pkt(2, 1, 1);
    build_exp(0);
    for (int n = 0; n < 20 && fq[1].size() != 0; n++) tick();
    chk("to_fifo1_drained", 32'(fq[1].size()), 32'd0);
    for (int k = 1; k <= 15; k++) tick();
    chk("to_no_early_abort", 32'(n_abort), 32'd0);
    chk("to_still_granted", 32'(grant_vld), 32'd1);
    tick();
    chk("to_abort", 32'(abort_pulse), 32'd1);
    chk("to_gvld_off", 32'(grant_vld), 32'd0);
    tick();
    chk("to_abort_pulse_len", 32'(abort_pulse), 32'd0);
    chk("to_next_grant", 32'({grant_vld, grant_idx}), 32'({1'b1, 3'd2}));
    drain(100);
    chk("to_abort_count", 32'(n_abort), 32'd1);

    // Zero-length packets back to back
    do_reset();
    push_pkt(0, 0, 0);
    push_pkt(4, 0, 0);
    build_exp(0);
    tick();
    chk("z_g0", 32'({grant_vld, grant_idx}), 32'({1'b1, 3'd0}));
    tick();
    chk("z_w0", 32'({oif.out_valid, oif.out_sop, oif.out_eop}), 32'd7);
    chk("z_idle_gap", 32'(grant_vld), 32'd0);
    tick();
    chk("z_g4", 32'({grant_vld, grant_idx}), 32'({1'b1, 3'd4}));
    chk("z_bubble", 32'(oif.out_valid), 32'd0);
    tick();
    chk("z_w4", 32'({oif.out_valid, oif.out_sop, oif.out_eop}), 32'd7);
    drain(50);

    // Asynchronous reset during payload word 2 of a len-6 packet
    do_reset();
    push_pkt(3, 6, 6);
    build_exp(0);
    tick(); tick(); tick(); tick();
    #2 rst_n = 1'b0; chk_en = 0;
    #1;
    chk("ar_valid", 32'(oif.out_valid), 32'd0);
    chk("ar_data", 32'(oif.out_data), 32'd0);
    chk("ar_grant", 32'({grant_vld, grant_idx}), 32'd0);
    chk("ar_rden", 32'(rd_en), 32'd0);
    chk("ar_abort", 32'(abort_pulse), 32'd0);
    for (int i = 0; i < 5; i++) fq[i].delete();
    exp_q.delete(); gseq.delete(); n_abort = 0;
    push_pkt(4, 2, 2);
    push_pkt(0, 1, 1);
    tick(); tick();
    rst_n = 1'b1; chk_en = 1; prev_stall = 0;
    build_exp(0);
    tick();
    chk("ar_restart_fifo0", 32'({grant_vld, grant_idx}), 32'({1'b1, 3'd0}));
    drain(100);
    chk("ar_no_abort", 32'(n_abort), 32'd0);

    // Random packet mixes with random backpressure
    for (int it = 0; it < 4; it++) begin
      do_reset();
      rdy_mode = 1;
      for (int f = 0; f < 5; f++) begin
        int np;
        np = $urandom_range(0, 3);
        for (int k = 0; k < np; k++) begin
          int ln;
          ln = $urandom_range(0, 15);
          push_pkt(f, ln, ln);
        end
      end
      build_exp(0);
      drain(3000);
      chk("rnd_no_abort", 32'(n_abort), 32'd0);
    end
    rdy_mode = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
